// File: rtl/scroll_msg_display.sv
// Scrolling 7-segment message engine: a NUM_DIGITS-wide window slides over a glyph buffer.
// Optional blink mode is enabled by defining SCROLL_MSG_DISPLAY_BLINK_EN.
module scroll_msg_display #(
  parameter int              NUM_DIGITS = 8,
  parameter int              MSG_DEPTH  = 16,
  parameter int              SEG_W      = 8,
  parameter int              DIV_W      = 16,
  parameter logic [SEG_W-1:0] BLANK     = 8'hFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
  input  logic [SEG_W-1:0]               wr_data,
  input  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
  input  logic [DIV_W-1:0]               div,
  input  logic                           dir,
  input  logic                           start,
  input  logic                           stop,
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
  input  logic                           blink,
`endif
  output logic [NUM_DIGITS*SEG_W-1:0]    seg_out,
  output logic                           busy,
  output logic                           wrap_pulse
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = $clog2(MSG_DEPTH+1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [SEG_W-1:0]            r_buf [MSG_DEPTH];
  logic [0:0]                  r_state;
  logic [LW-1:0]               r_ptr;
  logic [LW-1:0]               r_len;
  logic [DIV_W-1:0]            r_div;
  logic [DIV_W-1:0]            r_presc;
  logic                        r_dir;
  logic [NUM_DIGITS*SEG_W-1:0] r_seg;
  logic                        r_wrap;
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
  logic                        r_phase;
`endif

  logic                        w_run;
  logic                        w_tick;
  logic                        w_hold;
  logic                        w_start_ok;
  logic [LW-1:0]               w_len_in;
  logic [LW-1:0]               w_last;
  logic [LW-1:0]               w_ptr_next;
  logic                        w_wrap_next;
  logic [NUM_DIGITS*SEG_W-1:0] w_frame;
  logic [NUM_DIGITS*SEG_W-1:0] w_frame_out;

  assign w_run      = (r_state == S_RUN);
  assign w_tick     = w_run && (r_presc == r_div);
  assign w_start_ok = start && !stop && (msg_len != '0);
  assign w_last     = r_len - LW'(1);
  // Lengths beyond the buffer are clamped so indexing never leaves the buffer.
  assign w_len_in   = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;

`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
  assign w_hold      = blink;
  assign w_frame_out = r_phase ? {NUM_DIGITS{BLANK}} : w_frame;
`else
  assign w_hold      = 1'b0;
  assign w_frame_out = w_frame;
`endif

  always_comb begin
    w_ptr_next  = r_ptr;
    w_wrap_next = 1'b0;
    if (!r_dir) begin
      if (r_ptr == w_last) begin
        w_ptr_next  = '0;
        w_wrap_next = 1'b1;
      end else begin
        w_ptr_next = r_ptr + LW'(1);
      end
    end else begin
      if (r_ptr == '0) begin
        w_ptr_next  = w_last;
        w_wrap_next = 1'b1;
      end else begin
        w_ptr_next = r_ptr - LW'(1);
      end
    end
  end

  // Each digit index is the previous one plus one, folded back to 0 at len: no divider needed.
  always_comb begin : frame_build
    logic [LW-1:0] v_idx;
    w_frame = '0;
    v_idx   = r_ptr;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_frame[i*SEG_W +: SEG_W] = r_buf[v_idx[AW-1:0]];
      v_idx = (v_idx == w_last) ? '0 : v_idx + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < MSG_DEPTH))
      r_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_div   <= '0;
      r_presc <= '0;
      r_dir   <= 1'b0;
      r_seg   <= {NUM_DIGITS{BLANK}};
      r_wrap  <= 1'b0;
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
      r_phase <= 1'b0;
`endif
    end else begin
      r_wrap <= 1'b0;
      if (w_run && !stop)
        r_seg <= w_frame_out;
      if (w_run && stop) begin
        r_state <= S_IDLE;
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
        r_phase <= 1'b0;
`endif
      end else if (w_start_ok) begin
        r_state <= S_RUN;
        r_len   <= w_len_in;
        r_div   <= div;
        r_dir   <= dir;
        r_ptr   <= '0;
        r_presc <= '0;
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
        r_phase <= 1'b0;
`endif
      end else if (w_run) begin
        r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
        if (w_tick && !w_hold) begin
          r_ptr  <= w_ptr_next;
          r_wrap <= w_wrap_next;
        end
`ifdef SCROLL_MSG_DISPLAY_BLINK_EN
        if (!w_hold)
          r_phase <= 1'b0;
        else if (w_tick)
          r_phase <= ~r_phase;
`endif
      end
    end
  end

  assign seg_out    = r_seg;
  assign busy       = w_run;
  assign wrap_pulse = r_wrap;

endmodule
